// File: rtl/filter_mac_sequencer_pkg.sv
// Shared definitions for the FIR MAC sequencer: FSM state encodings and
// default address/counter widths used by the sequencer and its datapath.
package filter_mac_sequencer_pkg;

    localparam int unsigned AW_DEF    = 5;
    localparam int unsigned CNT_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_MAC   = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_e;

endpackage

// File: rtl/filter_mac_sequencer_if.sv
// Control/command bundle between the sample-rate strobe / register file and
// the FIR datapath. The master modport is the sequencer itself (it drives
// the datapath commands); the slave modport is the surrounding logic.
interface filter_mac_sequencer_if
    import filter_mac_sequencer_pkg::*;
#(
    parameter int unsigned AW    = AW_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) ();

    // strobe / register-file side
    logic             sample_stb;
    logic             rf_enable;
    logic [AW:0]      rf_ntaps;
    logic             trig_out_clear;

    // datapath command side
    logic             sample_we;
    logic [AW-1:0]    wr_ptr;
    logic             acc_clr;
    logic             mac_en;
    logic [AW-1:0]    coef_addr;
    logic [AW-1:0]    data_addr;
    logic             final_state;
    logic             out_valid;
    logic             busy;
    logic             overrun;
    logic [CNT_W-1:0] drop_cnt;

    modport master (
        input  sample_stb, rf_enable, rf_ntaps, trig_out_clear,
        output sample_we, wr_ptr, acc_clr, mac_en, coef_addr, data_addr,
               final_state, out_valid, busy, overrun, drop_cnt
    );

    modport slave (
        output sample_stb, rf_enable, rf_ntaps, trig_out_clear,
        input  sample_we, wr_ptr, acc_clr, mac_en, coef_addr, data_addr,
               final_state, out_valid, busy, overrun, drop_cnt
    );

endinterface

// File: rtl/filter_mac_sequencer_addr_gen.sv
// Tap counter and address generator: holds the latched (clamped) tap count,
// the current tap index k, the circular sample-buffer write pointer and the
// registered coefficient/data addresses presented during MAC cycles.
module filter_mac_sequencer_addr_gen
    import filter_mac_sequencer_pkg::*;
#(
    parameter int unsigned AW = AW_DEF
) (
    input  logic          i_clk,
    input  logic          i_rstb,
    input  logic          i_latch,     // capture tap count for the new sample
    input  logic [AW:0]   i_ntaps,
    input  logic          i_start,     // LOAD: first MAC cycle follows
    input  logic          i_step,      // MAC: advance to next tap
    input  logic          i_ptr_inc,   // FINAL: newest sample committed
    output logic          o_last,      // current tap is the final one
    output logic [AW-1:0] o_coef_addr,
    output logic [AW-1:0] o_data_addr,
    output logic [AW-1:0] o_wr_ptr
);

    localparam logic [AW:0]   NTAPS   = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   ONE_W   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] ONE_A   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] ZERO_A  = {AW{1'b0}};

    // Zero taps still computes one product; more than the buffer holds is capped.
    function automatic logic [AW:0] clamp_ntaps(input logic [AW:0] n);
        logic [AW:0] r;
        if (n == {(AW+1){1'b0}}) begin
            r = ONE_W;
        end else if (n > NTAPS) begin
            r = NTAPS;
        end else begin
            r = n;
        end
        return r;
    endfunction

    logic [AW:0]   r_ntaps;
    logic [AW-1:0] r_k;
    logic [AW-1:0] r_data_addr;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   w_k_plus1;

    assign w_k_plus1   = {1'b0, r_k} + ONE_W;
    assign o_last      = (w_k_plus1 == r_ntaps);
    assign o_coef_addr = r_k;
    assign o_data_addr = r_data_addr;
    assign o_wr_ptr    = r_wr_ptr;

    // Latch the clamped tap count once per sample so mid-run changes are ignored.
    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb) begin
            r_ntaps <= ONE_W;
        end else if (i_latch) begin
            r_ntaps <= clamp_ntaps(i_ntaps);
        end else begin
            r_ntaps <= r_ntaps;
        end
    end

    // Tap index and data address walk together; both return to zero outside MAC.
    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb) begin
            r_k         <= ZERO_A;
            r_data_addr <= ZERO_A;
        end else if (i_start) begin
            r_k         <= ZERO_A;
            r_data_addr <= r_wr_ptr;
        end else if (i_step && !o_last) begin
            r_k         <= r_k + ONE_A;
            r_data_addr <= r_data_addr - ONE_A;
        end else begin
            r_k         <= ZERO_A;
            r_data_addr <= ZERO_A;
        end
    end

    // Write pointer advances after each completed sample and wraps naturally.
    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb) begin
            r_wr_ptr <= ZERO_A;
        end else if (i_ptr_inc) begin
            r_wr_ptr <= r_wr_ptr + ONE_A;
        end else begin
            r_wr_ptr <= r_wr_ptr;
        end
    end

endmodule

// File: rtl/filter_mac_sequencer.sv
// FIR MAC sequencer: one filter output per accepted input sample.
// IDLE -> LOAD -> MAC (ntaps cycles) -> FINAL -> DONE -> IDLE, with every
// command output registered alongside the state.
// Optional feature macro: FILTER_SEQ_OVERRUN_EN (sticky overrun flag and
// saturating dropped-strobe counter); without it both outputs are tied 0.
module filter_mac_sequencer
    import filter_mac_sequencer_pkg::*;
#(
    parameter int unsigned AW    = AW_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rstb,
    filter_mac_sequencer_if.master bus
);

    seq_state_e r_state;
    logic       r_sample_we;
    logic       r_acc_clr;
    logic       r_mac_en;
    logic       r_final_state;
    logic       r_out_valid;
    logic       r_busy;

    logic          w_start;
    logic          w_last;
    logic [AW-1:0] w_coef_addr;
    logic [AW-1:0] w_data_addr;
    logic [AW-1:0] w_wr_ptr;

    assign w_start = bus.sample_stb & bus.rf_enable & (r_state == ST_IDLE);

    filter_mac_sequencer_addr_gen #(.AW(AW)) u_addr_gen (
        .i_clk       (clk),
        .i_rstb      (rstb),
        .i_latch     (w_start),
        .i_ntaps     (bus.rf_ntaps),
        .i_start     (r_state == ST_LOAD),
        .i_step      (r_state == ST_MAC),
        .i_ptr_inc   (r_state == ST_FINAL),
        .o_last      (w_last),
        .o_coef_addr (w_coef_addr),
        .o_data_addr (w_data_addr),
        .o_wr_ptr    (w_wr_ptr)
    );

    // Sequencer FSM; each output is set on the edge that enters its state.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state       <= ST_IDLE;
            r_sample_we   <= 1'b0;
            r_acc_clr     <= 1'b0;
            r_mac_en      <= 1'b0;
            r_final_state <= 1'b0;
            r_out_valid   <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_sample_we   <= 1'b0;
            r_acc_clr     <= 1'b0;
            r_mac_en      <= 1'b0;
            r_final_state <= 1'b0;
            r_out_valid   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state     <= ST_LOAD;
                        r_sample_we <= 1'b1;
                        r_acc_clr   <= 1'b1;
                        r_busy      <= 1'b1;
                    end else begin
                        r_state     <= ST_IDLE;
                        r_busy      <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    r_state  <= ST_MAC;
                    r_mac_en <= 1'b1;
                    r_busy   <= 1'b1;
                end
                ST_MAC: begin
                    if (w_last) begin
                        r_state       <= ST_FINAL;
                        r_final_state <= 1'b1;
                    end else begin
                        r_state  <= ST_MAC;
                        r_mac_en <= 1'b1;
                    end
                    r_busy <= 1'b1;
                end
                ST_FINAL: begin
                    r_state     <= ST_DONE;
                    r_out_valid <= 1'b1;
                    r_busy      <= 1'b1;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sample_we   = r_sample_we;
    assign bus.acc_clr     = r_acc_clr;
    assign bus.mac_en      = r_mac_en;
    assign bus.final_state = r_final_state;
    assign bus.out_valid   = r_out_valid;
    assign bus.busy        = r_busy;
    assign bus.coef_addr   = w_coef_addr;
    assign bus.data_addr   = w_data_addr;
    assign bus.wr_ptr      = w_wr_ptr;

`ifdef FILTER_SEQ_OVERRUN_EN
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic             r_overrun;
    logic [CNT_W-1:0] r_drop_cnt;
    logic             w_drop;

    // A strobe seen outside IDLE is a lost sample.
    assign w_drop = bus.sample_stb & (r_state != ST_IDLE);

    // Sticky overrun and saturating drop count; a drop beats a coincident clear.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_overrun  <= 1'b0;
            r_drop_cnt <= CNT_ZERO;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
            if (bus.trig_out_clear) begin
                r_drop_cnt <= CNT_ONE;
            end else if (r_drop_cnt != CNT_MAX) begin
                r_drop_cnt <= r_drop_cnt + CNT_ONE;
            end else begin
                r_drop_cnt <= r_drop_cnt;
            end
        end else if (bus.trig_out_clear) begin
            r_overrun  <= 1'b0;
            r_drop_cnt <= CNT_ZERO;
        end else begin
            r_overrun  <= r_overrun;
            r_drop_cnt <= r_drop_cnt;
        end
    end

    assign bus.overrun  = r_overrun;
    assign bus.drop_cnt = r_drop_cnt;
`else
    logic w_unused_clear;

    assign w_unused_clear = bus.trig_out_clear;
    assign bus.overrun    = 1'b0;
    assign bus.drop_cnt   = {CNT_W{1'b0}};
`endif

endmodule
